// File: rtl/mandelbrot_invoker.sv
// mandelbrot_invoker
//   Caller-side driver for the mandelbrot HLS component. Job descriptors are queued in a small
//   FIFO and tagged on entry. Each job is issued as one call: the nine arguments are registered
//   and held, start is raised until the component accepts it, then the FSM waits for the return.
//   Each accepted return produces one tagged completion. Only one call is ever outstanding.
// Ports
//   clock, resetn            clock, asynchronous active-low reset
//   job_valid/job_ready      job descriptor handshake; job_args = {xmax,...,dy}, xmax in MSBs
//   start, busy              component call.valid / call.stall
//   done, stall              component return.valid / return.stall
//   xmax .. dy               argument conduits, stable from call issue until return acceptance
//   cpl_valid/cpl_ready      completion handshake; cpl_tag = tag of the completed job
//   pending                  FIFO occupancy (excludes the in-flight job)
//   err_timeout              sticky: a WAIT lasted TIMEOUT cycles without a return

module mandelbrot_invoker #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [287:0]            job_args,
    output logic                    start,
    input  logic                    busy,
    input  logic                    done,
    output logic                    stall,
    output logic [31:0]             xmax,
    output logic [31:0]             xmin,
    output logic [31:0]             ymax,
    output logic [31:0]             ymin,
    output logic [31:0]             maxiter,
    output logic [31:0]             xres,
    output logic [31:0]             yres,
    output logic [31:0]             dx,
    output logic [31:0]             dy,
    output logic                    cpl_valid,
    input  logic                    cpl_ready,
    output logic [TAG_W-1:0]        cpl_tag,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    err_timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StCall, StWait} state_e;

    // FIFO entry carries the tag alongside the arguments so the tag is fixed at push time.
    logic [TAG_W+287:0] mem [DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [TAG_W-1:0]   tag_q;
    logic               push, pop, empty, full;

    state_e             state_q;
    logic               start_q;
    logic [287:0]       args_q;
    logic [TAG_W-1:0]   cur_tag_q;
    logic               cpl_valid_q;
    logic [TAG_W-1:0]   cpl_tag_q;
    logic [TW-1:0]      timer_q;
    logic               err_q;

    assign pending   = wr_ptr_q - rd_ptr_q;
    assign full      = (pending == (AW + 1)'(DEPTH));
    assign empty     = (pending == '0);
    assign job_ready = !full;
    assign push      = job_valid && job_ready;
    assign pop       = (state_q == StIdle) && !empty;

    // The return is blocked while the completion slot still holds an undrained completion.
    assign stall       = cpl_valid_q && !cpl_ready;
    assign start       = start_q;
    assign cpl_valid   = cpl_valid_q;
    assign cpl_tag     = cpl_tag_q;
    assign err_timeout = err_q;

    assign xmax    = args_q[287:256];
    assign xmin    = args_q[255:224];
    assign ymax    = args_q[223:192];
    assign ymin    = args_q[191:160];
    assign maxiter = args_q[159:128];
    assign xres    = args_q[127:96];
    assign yres    = args_q[95:64];
    assign dx      = args_q[63:32];
    assign dy      = args_q[31:0];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {tag_q, job_args};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
                tag_q    <= tag_q + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            args_q      <= '0;
            cur_tag_q   <= '0;
            cpl_valid_q <= 1'b0;
            cpl_tag_q   <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            // A new completion in the same cycle overrides this drain below.
            if (cpl_valid_q && cpl_ready) begin
                cpl_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        {cur_tag_q, args_q} <= mem[rd_ptr_q[AW-1:0]];
                        start_q             <= 1'b1;
                        state_q             <= StCall;
                    end
                end
                StCall: begin
                    if (!busy) begin
                        start_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (done && !stall) begin
                        cpl_valid_q <= 1'b1;
                        cpl_tag_q   <= cur_tag_q;
                        state_q     <= StIdle;
                    end else if (TIMEOUT != 0) begin
                        // Saturating counter; the FSM keeps waiting after the flag sets.
                        if (timer_q != TMAX) begin
                            timer_q <= timer_q + TW'(1);
                        end
                        if (timer_q == TMAX - TW'(1)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_invoker.sv
// tb_mandelbrot_invoker
//   Directed bench for mandelbrot_invoker. Stimulus pushes jobs and records the expected call
//   arguments and completion tags in queues. A component model answers calls with done after a
//   programmable delay and checks the arguments it is called with; a monitor pops and compares
//   each completion tag on handshake.
//   Phasing: stimulus drives at negedge, monitor samples at +1, component model at +2.

module tb_mandelbrot_invoker;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 8;

    logic                  clock;
    logic                  resetn;
    logic                  job_valid;
    logic                  job_ready;
    logic [287:0]          job_args;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  stall;
    logic [31:0]           xmax, xmin, ymax, ymin, maxiter, xres, yres, dx, dy;
    logic                  cpl_valid;
    logic                  cpl_ready;
    logic [TAG_W-1:0]      cpl_tag;
    logic [2:0]            pending;
    logic                  err_timeout;
    logic [287:0]          args_now;

    int                    tests;
    int                    failed;
    logic [287:0]          exp_args_q[$];
    logic [TAG_W-1:0]      exp_cpl_q[$];
    logic [TAG_W-1:0]      next_tag;
    logic [TAG_W-1:0]      mon_tag;

    // Component model state
    int                    done_delay;
    bit                    done_en;
    int                    countdown;
    bit                    waiting, call_pend, ret_pend, in_flight;
    logic [287:0]          cur_args;

    assign args_now = {xmax, xmin, ymax, ymin, maxiter, xres, yres, dx, dy};

    mandelbrot_invoker #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_args    (job_args),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .stall       (stall),
        .xmax        (xmax),
        .xmin        (xmin),
        .ymax        (ymax),
        .ymin        (ymin),
        .maxiter     (maxiter),
        .xres        (xres),
        .yres        (yres),
        .dx          (dx),
        .dy          (dy),
        .cpl_valid   (cpl_valid),
        .cpl_ready   (cpl_ready),
        .cpl_tag     (cpl_tag),
        .pending     (pending),
        .err_timeout (err_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [287:0] mk(input logic [31:0] base);
        return {base, base + 32'd1, base + 32'd2, base + 32'd3, base + 32'd4,
                base + 32'd5, base + 32'd6, base + 32'd7, base + 32'd8};
    endfunction

    task automatic push_job(input logic [287:0] a);
        int n = 0;
        job_valid = 1'b1;
        job_args  = a;
        while (!job_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!job_ready) begin
            tests++;
            failed++;
            $display("FAIL push_timeout: job_ready got 0, required 1");
        end else begin
            exp_args_q.push_back(a);
            exp_cpl_q.push_back(next_tag);
            next_tag++;
        end
        @(negedge clock);
        job_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_cpl_q.size() != 0 || cpl_valid) && n < 400) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (exp_cpl_q.size() != 0) begin
            failed++;
            $display("FAIL %s_drain: got %0d completions outstanding, required 0", name,
                     exp_cpl_q.size());
        end
        @(negedge clock);
    endtask

    // Asserts reset, checks every output against its reset value, then releases.
    task automatic do_reset(input string name);
        resetn = 1'b0;
        #1;
        check({name, "_start"}, start, 0);
        check({name, "_stall"}, stall, 0);
        check({name, "_cpl_valid"}, cpl_valid, 0);
        check({name, "_cpl_tag"}, cpl_tag, 0);
        check({name, "_err"}, err_timeout, 0);
        check({name, "_args"}, args_now, 0);
        check({name, "_pending"}, pending, 0);
        check({name, "_job_ready"}, job_ready, 1);
        exp_args_q.delete();
        exp_cpl_q.delete();
        next_tag = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // Component model
    always begin
        @(negedge clock);
        #2;
        if (!resetn) begin
            done      = 1'b0;
            waiting   = 1'b0;
            call_pend = 1'b0;
            ret_pend  = 1'b0;
            in_flight = 1'b0;
        end else begin
            if (ret_pend) begin
                done      = 1'b0;
                in_flight = 1'b0;
            end
            if (call_pend) begin
                countdown = done_delay;
                waiting   = 1'b1;
                in_flight = 1'b1;
                cur_args  = args_now;
            end
            if (start) begin
                if (exp_args_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL call_unexpected: got start=1, required 0");
                end else begin
                    check("call_args", args_now, exp_args_q[0]);
                end
            end else if (in_flight) begin
                check("held_args", args_now, cur_args);
            end
            if (waiting && done_en) begin
                if (countdown == 0) begin
                    done    = 1'b1;
                    waiting = 1'b0;
                end else begin
                    countdown--;
                end
            end
            ret_pend  = done && !stall;
            call_pend = start && !busy;
            if (call_pend && exp_args_q.size() != 0) begin
                void'(exp_args_q.pop_front());
            end
        end
    end

    // Completion monitor
    always begin
        @(negedge clock);
        #1;
        if (resetn && cpl_valid && cpl_ready) begin
            if (exp_cpl_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL cpl_unexpected: got tag %0d, required no completion", cpl_tag);
            end else begin
                mon_tag = exp_cpl_q.pop_front();
                check("cpl_tag", cpl_tag, mon_tag);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        tests      = 0;
        failed     = 0;
        clock      = 1'b0;
        resetn     = 1'b1;
        job_valid  = 1'b0;
        job_args   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        cpl_ready  = 1'b1;
        done_en    = 1'b1;
        done_delay = 10;
        next_tag   = '0;
        #2;
        do_reset("rst0");

        // 1: single job, first start two cycles after the push, one start cycle only
        push_job({32'h4000_0000, mk(32'h100)} >> 32);
        check("t1_pending_after_push", pending, 1);
        check("t1_start_early", start, 0);
        @(negedge clock);
        check("t1_start", start, 1);
        check("t1_pending_popped", pending, 0);
        check("t1_xmax", xmax, 32'h4000_0000);
        @(negedge clock);
        check("t1_single_start", start, 0);
        wait_drain("t1");
        check("t1_no_timeout", err_timeout, 0);

        // 2: busy held for five start cycles
        done_delay = 2;
        busy = 1'b1;
        push_job(mk(32'h200));
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check("t2_start_held", start, 1);
            check("t2_xmax_held", xmax, 32'h200);
            @(negedge clock);
        end
        busy = 1'b0;
        check("t2_start_unbusy", start, 1);
        @(negedge clock);
        check("t2_accepted", start, 0);
        wait_drain("t2");

        // 3: DEPTH+1 jobs while the component refuses the call; tags restart from 0
        done_delay = 3;
        do_reset("rst3");
        busy = 1'b1;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            push_job(mk(32'h300 + 32'(i) * 32'h10));
        end
        check("t3_full_ready", job_ready, 0);
        check("t3_full_pending", pending, 4);
        job_valid = 1'b1;
        job_args  = mk(32'hdead);
        @(negedge clock);
        job_valid = 1'b0;
        check("t3_no_push_when_full", pending, 4);
        busy = 1'b0;
        wait_drain("t3");

        // 4: second return blocked by an undrained completion
        done_delay = 2;
        cpl_ready = 1'b0;
        push_job(mk(32'h400));
        push_job(mk(32'h500));
        n = 0;
        do begin
            @(negedge clock);
            #3;
            n++;
        end while (!(done && stall) && n < 100);
        check("t4_reached_stall", done && stall, 1);
        for (int i = 0; i < 3; i++) begin
            check("t4_stall", stall, 1);
            check("t4_first_tag_held", cpl_tag, 5);
            check("t4_outstanding", exp_cpl_q.size(), 2);
            @(negedge clock);
            #3;
        end
        @(negedge clock);
        cpl_ready = 1'b1;
        wait_drain("t4");

        // 5: no done for sixteen WAIT cycles sets the sticky timeout
        done_en = 1'b0;
        push_job(mk(32'h600));
        @(negedge clock);
        check("t5_start", start, 1);
        @(negedge clock);
        check("t5_in_wait", start, 0);
        repeat (15) @(negedge clock);
        check("t5_err_at_15", err_timeout, 0);
        @(negedge clock);
        check("t5_err_at_16", err_timeout, 1);
        repeat (5) @(negedge clock);
        check("t5_err_sticky", err_timeout, 1);
        done_en = 1'b1;
        wait_drain("t5");
        check("t5_err_after_done", err_timeout, 1);
        check("t5_last_tag", cpl_tag, 7);

        // 6: reset in the middle of WAIT with a job still queued
        done_en = 1'b0;
        push_job(mk(32'h700));
        push_job(mk(32'h800));
        repeat (6) @(negedge clock);
        check("t6_queued", pending, 1);
        do_reset("rst6");
        done_en = 1'b1;
        push_job(mk(32'h900));
        wait_drain("t6");
        check("t6_tag0", cpl_tag, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
